// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader: FSM state encodings and the
// frame sync marker that the host-side loader tooling also uses.
package uart_prog_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE     = 3'd0,
        LDR_GET_ADDR = 3'd1,
        LDR_GET_LEN  = 3'd2,
        LDR_GET_DATA = 3'd3,
        LDR_GET_CHK  = 3'd4
    } ldr_state_t;

    localparam logic [7:0] LDR_SYNC_BYTE = 8'hA5;

    // Frame checksum is a plain modulo-256 sum; carries are dropped.
    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// Byte stream from the UART receiver plus the RAM write port and CPU control
// signals driven by the loader (slave = loader side).
interface uart_prog_loader_if;
    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;
    logic       o_Mem_WE;
    logic [7:0] o_Mem_Addr;
    logic [7:0] o_Mem_Data;
    logic       o_Halt_CPU;
    logic       o_Done;
    logic       o_Error;

    modport slave (
        input  i_RX_DV, i_RX_Byte,
        output o_Mem_WE, o_Mem_Addr, o_Mem_Data, o_Halt_CPU, o_Done, o_Error
    );

    modport master (
        output i_RX_DV, i_RX_Byte,
        input  o_Mem_WE, o_Mem_Addr, o_Mem_Data, o_Halt_CPU, o_Done, o_Error
    );
endinterface

// File: rtl/uart_loader_timeout.sv
// Inter-byte timeout counter: counts while enabled, clears on each byte, and
// flags expiry once TIMEOUT_CLKS-1 idle clocks have elapsed.
module uart_loader_timeout #(
    parameter int unsigned TIMEOUT_CLKS = 2170000
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Enable,
    input  logic i_Clear,
    output logic o_Expire
);
    localparam int CW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] count;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            count <= '0;
        end else if (i_Clear || !i_Enable) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign o_Expire = i_Enable && (count == LAST);
endmodule

// File: rtl/uart_prog_loader.sv
// Framed program loader: SYNC, ADDR, LEN (0 = 256), DATA..., CHK -> RAM writes.
// Define UART_LOADER_TIMEOUT_EN to abort stalled frames after TIMEOUT_CLKS.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = LDR_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CLKS = 2170000
) (
    input logic               i_Clock,
    input logic               i_Reset,
    uart_prog_loader_if.slave bus
);
    ldr_state_t state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [8:0] cnt_q, cnt_d;
    logic [7:0] chk_q, chk_d;
    logic       we_q, we_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_data_q, mem_data_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic       timeout_hit;

`ifdef UART_LOADER_TIMEOUT_EN
    uart_loader_timeout #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timeout (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .i_Enable (state_q != LDR_IDLE),
        .i_Clear  (bus.i_RX_DV),
        .o_Expire (timeout_hit)
    );
`else
    logic unused_timeout_clks;
    assign unused_timeout_clks = ^TIMEOUT_CLKS;
    assign timeout_hit         = 1'b0;
`endif

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q    <= LDR_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            chk_q      <= '0;
            we_q       <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            chk_q      <= chk_d;
            we_q       <= we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        chk_d      = chk_q;
        we_d       = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        done_d     = 1'b0;
        error_d    = 1'b0;

        if (bus.i_RX_DV) begin
            // A byte accepted in the expiry cycle always takes precedence.
            case (state_q)
                LDR_IDLE: begin
                    if (bus.i_RX_Byte == SYNC_BYTE) state_d = LDR_GET_ADDR;
                end
                LDR_GET_ADDR: begin
                    addr_d  = bus.i_RX_Byte;
                    chk_d   = bus.i_RX_Byte;
                    state_d = LDR_GET_LEN;
                end
                LDR_GET_LEN: begin
                    cnt_d   = (bus.i_RX_Byte == 8'h00) ? 9'd256 : {1'b0, bus.i_RX_Byte};
                    chk_d   = chk_add(chk_q, bus.i_RX_Byte);
                    state_d = LDR_GET_DATA;
                end
                LDR_GET_DATA: begin
                    we_d       = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = bus.i_RX_Byte;
                    addr_d     = addr_q + 8'd1;
                    chk_d      = chk_add(chk_q, bus.i_RX_Byte);
                    cnt_d      = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) state_d = LDR_GET_CHK;
                end
                LDR_GET_CHK: begin
                    done_d  = (bus.i_RX_Byte == chk_q);
                    error_d = (bus.i_RX_Byte != chk_q);
                    state_d = LDR_IDLE;
                end
                default: state_d = LDR_IDLE;
            endcase
        end else if (timeout_hit) begin
            error_d = 1'b1;
            state_d = LDR_IDLE;
        end
    end

    assign bus.o_Mem_WE   = we_q;
    assign bus.o_Mem_Addr = mem_addr_q;
    assign bus.o_Mem_Data = mem_data_q;
    assign bus.o_Halt_CPU = (state_q != LDR_IDLE);
    assign bus.o_Done     = done_q;
    assign bus.o_Error    = error_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader; RAM writes are checked against a
// scoreboard filled as data bytes are sent.
module tb_uart_prog_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_prog_loader_if bus();

    uart_prog_loader #(
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (50)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int n_done     = 0;
    int n_err      = 0;
    logic [15:0] sb[$];
    logic [7:0]  payload[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every o_Mem_WE pulse must match the oldest queued write.
    always @(negedge clk) begin
        if (bus.o_Done === 1'b1) n_done++;
        if (bus.o_Error === 1'b1) n_err++;
        if (bus.o_Mem_WE === 1'b1) begin
            check("write_queued", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                check("write_addr_data", {16'h0, bus.o_Mem_Addr, bus.o_Mem_Data}, {16'h0, sb[0]});
                void'(sb.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bus.i_RX_DV   = 1'b1;
        bus.i_RX_Byte = b;
        @(negedge clk);
        bus.i_RX_DV   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] len_b, input bit corrupt);
        logic [7:0] chk;
        logic [7:0] ad;
        logic [7:0] sent;
        chk = a + len_b;
        ad  = a;
        send(8'hA5);
        check("halt_after_sync", 32'(bus.o_Halt_CPU), 32'd1);
        send(a);
        send(len_b);
        foreach (payload[i]) begin
            sb.push_back({ad, payload[i]});
            ad  = ad + 8'd1;
            chk = chk + payload[i];
            send(payload[i]);
        end
        check("halt_before_chk", 32'(bus.o_Halt_CPU), 32'd1);
        sent = corrupt ? 8'h00 : chk;
        send(sent);
        check("done_pulse", 32'(bus.o_Done), 32'(!corrupt));
        check("error_pulse", 32'(bus.o_Error), 32'(corrupt));
        check("halt_at_end", 32'(bus.o_Halt_CPU), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.o_Done), 32'd0);
        check("error_one_cycle", 32'(bus.o_Error), 32'd0);
        check("writes_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bus.i_RX_DV   = 1'b0;
        bus.i_RX_Byte = 8'h00;
        #1;
        check("reset_outputs", {22'h0, bus.o_Mem_WE, bus.o_Mem_Addr, bus.o_Mem_Data,
                                bus.o_Halt_CPU, bus.o_Done, bus.o_Error}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame, then the same frame with a bad checksum.
        payload = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h10, 8'h03, 1'b0);
        send_frame(8'h10, 8'h03, 1'b1);

        // Address wrap across FF -> 00.
        payload = '{8'h01, 8'h02, 8'h03};
        send_frame(8'hFE, 8'h03, 1'b0);

        // Garbage in IDLE is ignored; a sync value inside data is plain data.
        send(8'h00);
        send(8'hFF);
        send(8'hA4);
        check("halt_idle_garbage", 32'(bus.o_Halt_CPU), 32'd0);
        repeat (2) @(negedge clk);
        check("halt_idle_settled", 32'(bus.o_Halt_CPU), 32'd0);
        payload = '{8'hA5, 8'h5A};
        send_frame(8'h40, 8'h02, 1'b0);

        // LEN = 0 means 256 data bytes.
        payload.delete();
        for (int i = 0; i < 256; i++) payload.push_back(8'(i * 7 + 3));
        send_frame(8'h80, 8'h00, 1'b0);

        // Reset in the middle of the data phase.
        send(8'hA5);
        send(8'h20);
        send(8'h05);
        sb.push_back({8'h20, 8'h01});
        send(8'h01);
        sb.push_back({8'h21, 8'h02});
        send(8'h02);
        #2;
        check("halt_mid_data", 32'(bus.o_Halt_CPU), 32'd1);
        check("we_before_reset", 32'(bus.o_Mem_WE), 32'd1);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {22'h0, bus.o_Mem_WE, bus.o_Mem_Addr, bus.o_Mem_Data,
                                      bus.o_Halt_CPU, bus.o_Done, bus.o_Error}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("reset_writes_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);
        payload = '{8'h77};
        send_frame(8'h30, 8'h01, 1'b0);

`ifdef UART_LOADER_TIMEOUT_EN
        send(8'hA5);
        send(8'h10);
        repeat (49) @(negedge clk);
        check("timeout_not_yet", 32'(bus.o_Error), 32'd0);
        check("timeout_halt_held", 32'(bus.o_Halt_CPU), 32'd1);
        @(negedge clk);
        check("timeout_error", 32'(bus.o_Error), 32'd1);
        check("timeout_halt_drop", 32'(bus.o_Halt_CPU), 32'd0);
        @(negedge clk);
        check("timeout_error_clear", 32'(bus.o_Error), 32'd0);
`endif

        @(negedge clk);
        check("done_total", 32'(n_done), 32'd5);
`ifdef UART_LOADER_TIMEOUT_EN
        check("error_total", 32'(n_err), 32'd2);
`else
        check("error_total", 32'(n_err), 32'd1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
